// File: rtl/checksum_verifier.sv
// -----------------------------------------------------------------------------
// checksum_verifier
//
// Receive-side Internet checksum check. Accumulates the 16-bit one's complement
// sum of a received IP/UDP/TCP segment, including its transmitted checksum
// field, one beat per cycle. At end of packet it presents the folded sum and a
// pass flag (sum == 0xFFFF) and holds them until the parser takes them.
//
// Optional feature macro: CHECKSUM_VERIFIER_STATS_EN
//   When defined, adds saturating packet / error counters (pkt_count,
//   err_count). When undefined those ports and counters do not exist.
//
// Parameters:
//   DATA_WIDTH  input word width, multiple of 16, 16..128
//   CNT_WIDTH   statistics counter width (used only with the stats feature)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_data    packet word, first byte in the MSBs (network order)
//   in_keep    byte enables; in_keep[j] qualifies in_data[8j+7:8j], so the
//              MSB of in_keep belongs to the first byte on the wire
//   in_valid   in_data / in_keep / in_last valid
//   in_last    final beat of the packet
//   in_ready   beat accepted when in_valid && in_ready (high while accumulating)
//   res_valid  result available
//   res_ok     1 = checksum correct
//   res_sum    final folded one's complement sum
//   res_ready  result consumed when res_valid && res_ready
//   pkt_count  (stats only) results handed over, saturating
//   err_count  (stats only) results handed over with res_ok = 0, saturating
// -----------------------------------------------------------------------------
module checksum_verifier #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_keep,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    res_valid,
    output logic                    res_ok,
    output logic [15:0]             res_sum,
    input  logic                    res_ready
`ifdef CHECKSUM_VERIFIER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    err_count
`endif
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int NUM_LANES = DATA_WIDTH / 16;
    // Wide enough for the accumulator plus every lane without overflow.
    localparam int SUM_W     = 16 + $clog2(NUM_LANES + 1);

    if (DATA_WIDTH % 16 != 0 || DATA_WIDTH < 16 || DATA_WIDTH > 128 || CNT_WIDTH < 1)
    begin : g_param_check
        $error("checksum_verifier: unsupported parameter value");
    end

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] res_sum_q, res_sum_d;
    logic        res_ok_q, res_ok_d;

    // -------------------------------------------------------------------------
    // Beat sum: mask disabled bytes, add all lanes to the accumulator, then
    // fold twice. A dropped odd trailing byte leaves its partner zero-padded in
    // the low half of the lane, as RFC 1071 requires.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] masked_data;
    logic [SUM_W-1:0]      beat_sum;
    logic [16:0]           fold1;
    logic [15:0]           acc_new;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path can leave it holding its old value (which would infer a latch).
        masked_data = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            masked_data[8*b +: 8] = in_data[8*b +: 8] & {8{in_keep[b]}};
        end

        beat_sum = SUM_W'(acc_q);
        for (int k = 0; k < NUM_LANES; k++) begin
            beat_sum = beat_sum + SUM_W'(masked_data[DATA_WIDTH-1-16*k -: 16]);
        end

        // First fold leaves at most 0xFFFF + a few carries (17 bits); when bit
        // 16 is set the low half is tiny, so the second fold cannot overflow.
        fold1   = {1'b0, beat_sum[15:0]} + 17'(beat_sum[SUM_W-1:16]);
        acc_new = fold1[15:0] + 16'(fold1[16]);
    end

    // -------------------------------------------------------------------------
    // Control: ACCUM takes beats, RESULT holds the verdict until handed over.
    // Input beats are ignored in RESULT because in_ready is low there.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_sum_d = res_sum_q;
        res_ok_d  = res_ok_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_new;
                    if (in_last) begin
                        res_sum_d = acc_new;
                        res_ok_d  = (acc_new == 16'hFFFF);
                        state_d   = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            res_sum_q <= '0;
            res_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            res_sum_q <= res_sum_d;
            res_ok_q  <= res_ok_d;
        end
    end

    // Handshake flags decode straight from the registered state.
    assign in_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == RESULT);
    assign res_sum   = res_sum_q;
    assign res_ok    = res_ok_q;

`ifdef CHECKSUM_VERIFIER_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: counted on the result handshake, saturating at all-ones.
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 res_handshake;

    assign res_handshake = (state_q == RESULT) && res_ready;

    always_comb begin
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (res_handshake) begin
            if (pkt_count_q != '1) begin
                pkt_count_d = pkt_count_q + 1'b1;
            end
            if (!res_ok_q && err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_checksum_verifier.sv
// -----------------------------------------------------------------------------
// tb_checksum_verifier
//
// Self-checking bench for checksum_verifier (DATA_WIDTH = 32). Directed cases
// cover the documented scenarios; random packets are checked against a
// reference that adds the whole packet's 16-bit words as plain integers and
// applies end-around carry once at the end. Define CHECKSUM_VERIFIER_STATS_EN
// to also exercise the saturating counters (CNT_WIDTH = 2).
// -----------------------------------------------------------------------------
module tb_checksum_verifier;

    localparam int DW = 32;
    localparam int CW = 2;

    typedef logic [31:0] word_q_t[$];
    typedef logic [3:0]  keep_q_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [3:0]    in_keep;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          res_valid;
    logic          res_ok;
    logic [15:0]   res_sum;
    logic          res_ready;
`ifdef CHECKSUM_VERIFIER_STATS_EN
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    checksum_verifier #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ok    (res_ok),
        .res_sum   (res_sum),
        .res_ready (res_ready)
`ifdef CHECKSUM_VERIFIER_STATS_EN
        ,
        .pkt_count (pkt_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the byte at wire position b (0 = first) is the high half of a
    // 16-bit word when b is even, the low half when odd; dropped bytes count 0.
    function automatic logic [15:0] ref_sum(input word_q_t words, input keep_q_t keeps);
        longint total = 0;
        for (int i = 0; i < words.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                if (keeps[i][3-b]) begin
                    longint byte_val = longint'(words[i][31-8*b -: 8]);
                    total += (b % 2 == 0) ? byte_val * 256 : byte_val;
                end
            end
        end
        while ((total >> 16) != 0) total = (total & 64'hFFFF) + (total >> 16);
        return total[15:0];
    endfunction

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int guard = 0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_packet(input word_q_t words, input keep_q_t keeps, input int max_gap);
        for (int i = 0; i < words.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
            end
            send_beat(words[i], keeps[i], i == words.size() - 1);
        end
    endtask

    // Called right after the last beat's edge: checks one-cycle latency, the
    // verdict, then performs the handshake after 'hold' stall cycles.
    task automatic expect_result(input string tag, input logic [15:0] exp_sum, input int hold);
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_in_ready_low"}, in_ready, 0);
        check({tag, "_res_sum"}, res_sum, exp_sum);
        check({tag, "_res_ok"}, res_ok, exp_sum == 16'hFFFF);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_res_valid_clr"}, res_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_ok"}, res_ok, 0);
        check({tag, "_res_sum"}, res_sum, 0);
    endtask

    task automatic send_test1(input string tag);
        send_beat(32'h0001_0002, 4'b1111, 1'b0);
        send_beat(32'hFFFC_0000, 4'b1111, 1'b1);
        expect_result(tag, 16'hFFFF, 0);
    endtask

    task automatic send_bad(input string tag);
        send_beat(32'h1234_5678, 4'b1110, 1'b1);
        expect_result(tag, 16'h6834, 0);
    endtask

    initial begin
        word_q_t words;
        keep_q_t keeps;
        logic [15:0] exp_sum;

        reset     = 1'b1;
        in_data   = '0;
        in_keep   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset("reset");
        reset = 1'b0;

        // 1: basic good packet.
        send_test1("t1");

        // 2: carry wrap; acc is 0xFFFF after the first beat.
        send_beat(32'hFFFF_FFFF, 4'b1111, 1'b0);
        send_beat(32'h0001_0000, 4'b1111, 1'b1);
        expect_result("t2", 16'h0001, 0);

        // 3: odd trailing byte dropped.
        send_bad("t3");

        // 4: backpressure with junk on the input; nothing may be accepted.
        send_beat(32'h0001_0002, 4'b1111, 1'b0);
        send_beat(32'hFFFC_0000, 4'b1111, 1'b1);
        in_valid = 1'b1;
        in_keep  = 4'b1111;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            @(posedge clk); #1;
            check($sformatf("t4_hold_valid_%0d", i), res_valid, 1);
            check($sformatf("t4_hold_sum_%0d", i), res_sum, 16'hFFFF);
            check($sformatf("t4_hold_ok_%0d", i), res_ok, 1);
            check($sformatf("t4_hold_ready_%0d", i), in_ready, 0);
        end
        in_data   = 32'h1111_2222;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("t4_in_ready_back", in_ready, 1);
        check("t4_res_valid_clr", res_valid, 0);
        send_test1("t4_after");

        // 5: reset in the middle of a packet discards it.
        send_beat(32'hAAAA_5555, 4'b1111, 1'b0);
        send_beat(32'hAAAA_5555, 4'b1111, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_reset("t5_reset");
        send_test1("t5_after");

        // Reset while holding a result.
        send_bad("t5b_pre");
        send_beat(32'h0102_0304, 4'b1111, 1'b1);
        check("t5b_res_valid", res_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_reset("t5b_reset");

        // Random packets; even ones carry a closing word that makes them good.
        for (int p = 0; p < 40; p++) begin
            int n;
            words = {};
            keeps = {};
            n = $urandom_range(6, 1);
            for (int i = 0; i < n - 1; i++) begin
                words.push_back($urandom);
                keeps.push_back(4'b1111);
            end
            if (p % 2 == 0) begin
                logic [15:0] partial;
                partial = ref_sum(words, keeps);
                words.push_back({~partial, 16'h0000});
                keeps.push_back(4'b1111);
            end else begin
                logic [3:0] k;
                case ($urandom_range(3, 0))
                    0:       k = 4'b1000;
                    1:       k = 4'b1100;
                    2:       k = 4'b1110;
                    default: k = 4'b1111;
                endcase
                words.push_back($urandom);
                keeps.push_back(k);
            end
            exp_sum = ref_sum(words, keeps);
            send_packet(words, keeps, 2);
            expect_result($sformatf("rand%0d", p), exp_sum, $urandom_range(3, 0));
        end

`ifdef CHECKSUM_VERIFIER_STATS_EN
        // 6: saturating statistics counters.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_pkt_reset", pkt_count, 0);
        check("t6_err_reset", err_count, 0);
        send_test1("t6_good0");
        send_test1("t6_good1");
        send_bad("t6_bad0");
        check("t6_pkt_count", pkt_count, 3);
        check("t6_err_count", err_count, 1);
        for (int i = 0; i < 4; i++) send_bad($sformatf("t6_bad_sat%0d", i));
        check("t6_pkt_sat", pkt_count, 3);
        check("t6_err_sat", err_count, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
